matmul_res_checker: RTL and testbench
=====================================

Name: matmul_res_checker

Overview:
Synthesizable streaming result checker for the matmul accelerator verification environment. It compares a DUT result-matrix stream against a golden stream element by element, in row-major order, with LANES elements per beat. It supports exact or tolerance compare, counts mismatches, latches the first failing index, and runs a stall watchdog. It replaces file-based end-of-run comparison, so benches and FPGA self-test report pass/fail and done directly.

Parameters:
DATA_WIDTH, 32, width of one signed result element
LANES, 2, elements carried per beat (1..8)
MAX_DIM, 4, maximum rows/cols of the result matrix
CNT_WIDTH, 16, width of the mismatch counter (saturating)
TIMEOUT_CYCLES, 1024, idle cycles in RUN without a handshake before timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  one-cycle start pulse; sampled only in IDLE or DONE
rows_i  in  $clog2(MAX_DIM+1)  result rows, captured on start
cols_i  in  $clog2(MAX_DIM+1)  result cols, captured on start
tol_i  in  DATA_WIDTH  unsigned tolerance, captured on start; 0 = exact compare
dut_valid_i  in  1  DUT beat valid
dut_ready_o  out  1  DUT beat accepted
dut_data_i  in  LANES*DATA_WIDTH  DUT elements, lane 0 in LSBs = lowest index
gold_valid_i  in  1  golden beat valid
gold_ready_o  out  1  golden beat accepted
gold_data_i  in  LANES*DATA_WIDTH  golden elements, same packing as DUT
busy_o  out  1  high in RUN
done_o  out  1  high in DONE, held until next start or reset
pass_o  out  1  valid when done_o: 1 iff mismatch count is 0 and no timeout
timeout_o  out  1  watchdog fired in this run
mismatch_cnt_o  out  CNT_WIDTH  mismatching elements, saturating at all-ones
first_err_valid_o  out  1  at least one mismatch seen
first_err_idx_o  out  $clog2(MAX_DIM*MAX_DIM)+1  row-major index of the first mismatching element

Behaviour:
- Reset (async, rst_i=1): FSM goes to IDLE. All outputs and counters are 0, including pass_o and both ready outputs. Captured rows, cols and tol are cleared. Reset asserted mid-RUN aborts the run with no done_o pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start_i: capture rows, cols, tol; clear counters, timeout, first_err and done. Go to RUN. If rows*cols==0, go to DONE directly with pass_o=1 on the next cycle.
  - start_i while in RUN is ignored.
  - RUN goes to DONE on the last-beat handshake or on watchdog expiry.
- Handshake (join):
  - dut_ready_o = gold_ready_o = (state==RUN) && dut_valid_i && gold_valid_i.
  - A beat transfers only when both valids are high in the same cycle.
  - Neither stream is consumed alone. Ready is never asserted outside RUN.
- Element count: total = rows*cols. Beats needed = ceil(total/LANES). The index counter advances by LANES per beat.
- Lanes in the final beat whose index >= total are ignored. They are not counted and cannot mismatch.
- Compare per lane, combinational on the handshake cycle:
  - diff = signed extension to DATA_WIDTH+1 of (dut - gold).
  - mismatch = |diff| > tol, using an unsigned compare at DATA_WIDTH+1 bits. With tol=0 this reduces to exact equality.
- Registered update at the handshake edge:
  - mismatch_cnt += number of mismatching valid lanes, saturating.
  - If first_err_valid_o==0 and any lane mismatches, latch index = beat base + lowest mismatching lane, and set first_err_valid_o.
- Latency: done_o, pass_o and the final counts are visible the cycle after the last-beat handshake. The counts reflect that last beat.
- Watchdog:
  - The counter resets on start and on every handshake, and increments each RUN cycle without one.
  - At TIMEOUT_CYCLES it sets timeout_o=1 and goes to DONE with pass_o=0.
  - Counts reflect only the beats actually received.
- If a handshake and watchdog expiry occur in the same cycle, the handshake wins and the watchdog clears.
- busy_o = (state==RUN). done_o and busy_o are never both high.

Test Plan:
- 2x2 exact, LANES=2, beats {5,-3},{7,0} on both streams, tol=0 -> 2 handshakes, done_o the cycle after the 2nd, pass_o=1, mismatch_cnt_o=0.
- 3x3, LANES=2, golden all 10, DUT element 4 = 13 and element 8 = 0, tol=0 -> 5 beats; last beat lane 1 ignored; mismatch_cnt_o=2, first_err_idx_o=4, pass_o=0.
- Tolerance: gold {100,100}, DUT {102,97}, tol=2 -> lane 0 passes, lane 1 fails; cnt=1, first_err_idx_o=1. With tol=3 -> pass_o=1. Also gold 0x7FFFFFFF vs DUT 0x80000000 with tol=5 -> mismatch (no wrap).
- Join backpressure: dut_valid high for 4 cycles while gold_valid stays low -> readies stay 0 and nothing is consumed. When gold_valid rises -> both readies high that cycle and the beat is compared.
- Watchdog with TIMEOUT_CYCLES=8: 2x2 run, 1 beat, then no valids -> 8 cycles later done_o=1, timeout_o=1, pass_o=0, cnt from 1 beat only. A start_i pulse during RUN is ignored.
- rst_i asserted mid-RUN (async, between edges) -> all outputs immediately 0, FSM in IDLE. rows=0 start -> done_o=1, pass_o=1 the next cycle.

Source files
------------

// File: rtl/matmul_res_checker.sv
// Streaming result checker: joins a DUT and a golden beat stream, compares LANES elements per beat
// (exact or within tolerance), counts mismatches, latches the first failing index, watches for stalls.
module matmul_res_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int LANES          = 2,
  parameter int MAX_DIM        = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic [$clog2(MAX_DIM+1)-1:0]       rows_i,
  input  logic [$clog2(MAX_DIM+1)-1:0]       cols_i,
  input  logic [DATA_WIDTH-1:0]              tol_i,
  input  logic                               dut_valid_i,
  output logic                               dut_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0]        dut_data_i,
  input  logic                               gold_valid_i,
  output logic                               gold_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0]        gold_data_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               pass_o,
  output logic                               timeout_o,
  output logic [CNT_WIDTH-1:0]               mismatch_cnt_o,
  output logic                               first_err_valid_o,
  output logic [$clog2(MAX_DIM*MAX_DIM):0]   first_err_idx_o
);
  localparam int DIM_W = $clog2(MAX_DIM+1);
  localparam int IDX_W = $clog2(MAX_DIM*MAX_DIM) + 1;
  localparam int POS_W = IDX_W + 4;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES+1);
  localparam int NUM_W = $clog2(LANES+1);
  localparam int SUM_W = CNT_WIDTH + NUM_W;

  // IDLE: wait for start | RUN: consume beats | DONE: hold result until next start
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [DIM_W-1:0]      rows, cols;
  logic [DATA_WIDTH-1:0] tol;
  logic [POS_W-1:0]      base, total, total_in;
  logic [WD_W-1:0]       wd;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  timeout, ferr_valid;
  logic [IDX_W-1:0]      ferr_idx, err_idx;
  logic                  accept, hs, last_beat, wd_expire;
  logic [LANES-1:0]      lane_err;
  logic [NUM_W-1:0]      n_err;
  logic [SUM_W-1:0]      sum;
  logic [CNT_WIDTH-1:0]  cnt_sat;

  assign total_in  = POS_W'(rows_i) * POS_W'(cols_i);
  assign total     = POS_W'(rows) * POS_W'(cols);
  assign accept    = start_i && (state != RUN);
  assign hs        = (state == RUN) && dut_valid_i && gold_valid_i;
  assign last_beat = hs && ((base + POS_W'(LANES)) >= total);
  assign wd_expire = (state == RUN) && !hs && (wd == WD_W'(TIMEOUT_CYCLES - 1));

  // One extra bit keeps the difference of two extreme signed values from wrapping.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_WIDTH:0] dut_e, gold_e, diff, mag;
    assign dut_e  = {dut_data_i[l*DATA_WIDTH + DATA_WIDTH-1], dut_data_i[l*DATA_WIDTH +: DATA_WIDTH]};
    assign gold_e = {gold_data_i[l*DATA_WIDTH + DATA_WIDTH-1], gold_data_i[l*DATA_WIDTH +: DATA_WIDTH]};
    assign diff   = dut_e - gold_e;
    assign mag    = diff[DATA_WIDTH] ? -diff : diff;
    assign lane_err[l] = ((base + POS_W'(l)) < total) && (mag > {1'b0, tol});
  end

  always_comb begin
    n_err   = '0;
    err_idx = '0;
    for (int l = LANES-1; l >= 0; l--) begin
      n_err = n_err + NUM_W'(lane_err[l]);
      if (lane_err[l]) err_idx = IDX_W'(base) + IDX_W'(l);
    end
    sum     = SUM_W'(cnt) + SUM_W'(n_err);
    cnt_sat = (sum[SUM_W-1:CNT_WIDTH] != '0) ? '1 : sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_i) state_nxt = (total_in == '0) ? DONE : RUN;
      RUN:        if (last_beat || wd_expire) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state == RUN);
    done_o       = (state == DONE);
    pass_o       = (state == DONE) && (cnt == '0) && !timeout;
    dut_ready_o  = hs;
    gold_ready_o = hs;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rows       <= '0;
      cols       <= '0;
      tol        <= '0;
      base       <= '0;
      wd         <= '0;
      cnt        <= '0;
      timeout    <= 1'b0;
      ferr_valid <= 1'b0;
      ferr_idx   <= '0;
    end else if (accept) begin
      rows       <= rows_i;
      cols       <= cols_i;
      tol        <= tol_i;
      base       <= '0;
      wd         <= '0;
      cnt        <= '0;
      timeout    <= 1'b0;
      ferr_valid <= 1'b0;
      ferr_idx   <= '0;
    end else if (state == RUN) begin
      if (hs) begin
        base <= base + POS_W'(LANES);
        wd   <= '0;
        cnt  <= cnt_sat;
        if (!ferr_valid && (lane_err != '0)) begin
          ferr_valid <= 1'b1;
          ferr_idx   <= err_idx;
        end
      end else if (wd_expire) begin
        timeout <= 1'b1;
      end else begin
        wd <= wd + 1'b1;
      end
    end
  end

  assign timeout_o         = timeout;
  assign mismatch_cnt_o    = cnt;
  assign first_err_valid_o = ferr_valid;
  assign first_err_idx_o   = ferr_idx;
endmodule

// File: tb/tb_matmul_res_checker.sv
// Directed bench for matmul_res_checker (LANES=2, MAX_DIM=4, watchdog shortened to 8 cycles).
module tb_matmul_res_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  rows = '0, cols = '0;
  logic [31:0] tol = '0;
  logic        dut_valid = 1'b0, gold_valid = 1'b0;
  logic        dut_ready, gold_ready;
  logic [63:0] dut_data = '0, gold_data = '0;
  logic        busy, done, pass, timeout, ferr_valid;
  logic [15:0] cnt;
  logic [4:0]  ferr_idx;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  matmul_res_checker #(
    .DATA_WIDTH(32), .LANES(2), .MAX_DIM(4), .CNT_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rows_i(rows), .cols_i(cols), .tol_i(tol),
    .dut_valid_i(dut_valid), .dut_ready_o(dut_ready), .dut_data_i(dut_data),
    .gold_valid_i(gold_valid), .gold_ready_o(gold_ready), .gold_data_i(gold_data),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .mismatch_cnt_o(cnt), .first_err_valid_o(ferr_valid), .first_err_idx_o(ferr_idx)
  );

  // Drivers: called at a falling edge, return at a falling edge.
  task automatic start_run(input logic [2:0] r, input logic [2:0] c, input logic [31:0] t);
    rows = r; cols = c; tol = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] g0, input logic [31:0] g1, output logic [1:0] rdy);
    dut_data = {d1, d0}; gold_data = {g1, g0};
    dut_valid = 1'b1; gold_valid = 1'b1;
    #1 rdy = {dut_ready, gold_ready};
    @(negedge clk);
    dut_valid = 1'b0; gold_valid = 1'b0;
  endtask

  task automatic test_reset();
    dut_valid = 1'b1; gold_valid = 1'b1;
    #12;
    n_checks++;
    if ({busy, done, pass, timeout, ferr_valid, dut_ready, gold_ready} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected 0000000",
                         {busy, done, pass, timeout, ferr_valid, dut_ready, gold_ready});
    end
    n_checks++;
    if ({cnt, ferr_idx} !== 21'd0) begin
      n_fail++; $display("FAIL reset_counts: got cnt=%0d idx=%0d, expected 0/0", cnt, ferr_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, dut_ready} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: got busy/done/ready=%b, expected 000", {busy, done, dut_ready});
    end
    dut_valid = 1'b0; gold_valid = 1'b0;
  endtask

  task automatic test_exact_2x2();
    logic [1:0] r0, r1;
    start_run(3'd2, 3'd2, 32'd0);
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++; $display("FAIL exact_running: got busy/done=%b, expected 10", {busy, done});
    end
    send_beat(32'd5, -32'sd3, 32'd5, -32'sd3, r0);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL exact_early_done: got %b, expected 0", done);
    end
    send_beat(32'd7, 32'd0, 32'd7, 32'd0, r1);
    n_checks++;
    if ({r0, r1} !== 4'b1111) begin
      n_fail++; $display("FAIL exact_readies: got %b, expected 1111", {r0, r1});
    end
    n_checks++;
    if ({busy, done, pass, ferr_valid} !== 4'b0110 || cnt !== 16'd0) begin
      n_fail++; $display("FAIL exact_result: got busy/done/pass/ferr=%b cnt=%0d, expected 0110 cnt=0",
                         {busy, done, pass, ferr_valid}, cnt);
    end
  endtask

  task automatic test_3x3_ignore();
    logic [1:0] r;
    start_run(3'd3, 3'd3, 32'd0);
    send_beat(32'd10, 32'd10, 32'd10, 32'd10, r);
    send_beat(32'd10, 32'd10, 32'd10, 32'd10, r);
    send_beat(32'd13, 32'd10, 32'd10, 32'd10, r);
    send_beat(32'd10, 32'd10, 32'd10, 32'd10, r);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL 3x3_done_after_4: got %b, expected 0", done);
    end
    send_beat(32'd0, 32'd99, 32'd10, 32'd10, r);
    n_checks++;
    if ({done, pass, ferr_valid} !== 3'b101) begin
      n_fail++; $display("FAIL 3x3_flags: got done/pass/ferr=%b, expected 101", {done, pass, ferr_valid});
    end
    n_checks++;
    if (cnt !== 16'd2) begin
      n_fail++; $display("FAIL 3x3_cnt: got %0d, expected 2", cnt);
    end
    n_checks++;
    if (ferr_idx !== 5'd4) begin
      n_fail++; $display("FAIL 3x3_first_idx: got %0d, expected 4", ferr_idx);
    end
  endtask

  task automatic test_tolerance();
    logic [1:0] r;
    start_run(3'd1, 3'd2, 32'd2);
    send_beat(32'd102, 32'd97, 32'd100, 32'd100, r);
    n_checks++;
    if ({done, pass} !== 2'b10 || cnt !== 16'd1 || ferr_idx !== 5'd1) begin
      n_fail++; $display("FAIL tol2: got done/pass=%b cnt=%0d idx=%0d, expected 10 cnt=1 idx=1",
                         {done, pass}, cnt, ferr_idx);
    end
    start_run(3'd1, 3'd2, 32'd3);
    send_beat(32'd102, 32'd97, 32'd100, 32'd100, r);
    n_checks++;
    if ({done, pass, ferr_valid} !== 3'b110 || cnt !== 16'd0) begin
      n_fail++; $display("FAIL tol3: got done/pass/ferr=%b cnt=%0d, expected 110 cnt=0",
                         {done, pass, ferr_valid}, cnt);
    end
    start_run(3'd1, 3'd2, 32'd5);
    send_beat(32'h8000_0000, 32'd7, 32'h7FFF_FFFF, 32'd7, r);
    n_checks++;
    if ({pass, ferr_valid} !== 2'b01 || cnt !== 16'd1 || ferr_idx !== 5'd0) begin
      n_fail++; $display("FAIL tol_extreme: got pass/ferr=%b cnt=%0d idx=%0d, expected 01 cnt=1 idx=0",
                         {pass, ferr_valid}, cnt, ferr_idx);
    end
  endtask

  task automatic test_backpressure();
    start_run(3'd1, 3'd2, 32'd0);
    dut_data = {32'd2, 32'd1}; gold_data = {32'd3, 32'd1};
    dut_valid = 1'b1; gold_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({dut_ready, gold_ready} !== 2'b00) begin
        n_fail++; $display("FAIL bp_ready_low cycle %0d: got %b, expected 00", i, {dut_ready, gold_ready});
      end
      @(negedge clk);
    end
    n_checks++;
    if ({busy, done} !== 2'b10 || cnt !== 16'd0) begin
      n_fail++; $display("FAIL bp_not_consumed: got busy/done=%b cnt=%0d, expected 10 cnt=0", {busy, done}, cnt);
    end
    gold_valid = 1'b1;
    #1;
    n_checks++;
    if ({dut_ready, gold_ready} !== 2'b11) begin
      n_fail++; $display("FAIL bp_ready_join: got %b, expected 11", {dut_ready, gold_ready});
    end
    @(negedge clk);
    dut_valid = 1'b0; gold_valid = 1'b0;
    n_checks++;
    if ({done, pass} !== 2'b10 || cnt !== 16'd1 || ferr_idx !== 5'd1) begin
      n_fail++; $display("FAIL bp_result: got done/pass=%b cnt=%0d idx=%0d, expected 10 cnt=1 idx=1",
                         {done, pass}, cnt, ferr_idx);
    end
  endtask

  task automatic test_watchdog();
    logic [1:0] r;
    start_run(3'd2, 3'd2, 32'd0);
    send_beat(32'd1, 32'd0, 32'd0, 32'd0, r);
    for (int i = 1; i <= 8; i++) begin
      start = (i == 3);
      if (i == 3) begin rows = 3'd1; cols = 3'd1; end
      @(negedge clk);
      start = 1'b0;
      if (i < 8) begin
        n_checks++;
        if (done !== 1'b0) begin
          n_fail++; $display("FAIL wd_early_done at idle cycle %0d: got %b, expected 0", i, done);
        end
      end
    end
    n_checks++;
    if ({busy, done, pass, timeout} !== 4'b0101) begin
      n_fail++; $display("FAIL wd_flags: got busy/done/pass/timeout=%b, expected 0101", {busy, done, pass, timeout});
    end
    n_checks++;
    if (cnt !== 16'd1 || ferr_idx !== 5'd0) begin
      n_fail++; $display("FAIL wd_counts: got cnt=%0d idx=%0d, expected cnt=1 idx=0", cnt, ferr_idx);
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] r;
    start_run(3'd2, 3'd2, 32'd0);
    send_beat(32'd1, 32'd0, 32'd0, 32'd0, r);
    dut_valid = 1'b1; gold_valid = 1'b1;
    #1;
    n_checks++;
    if ({busy, dut_ready, ferr_valid} !== 3'b111 || cnt !== 16'd1) begin
      n_fail++; $display("FAIL arst_pre: got busy/ready/ferr=%b cnt=%0d, expected 111 cnt=1",
                         {busy, dut_ready, ferr_valid}, cnt);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, pass, ferr_valid, dut_ready, gold_ready} !== 6'b0 || cnt !== 16'd0) begin
      n_fail++; $display("FAIL arst_immediate: got flags=%b cnt=%0d, expected 000000 cnt=0",
                         {busy, done, pass, ferr_valid, dut_ready, gold_ready}, cnt);
    end
    dut_valid = 1'b0; gold_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL arst_no_done: got busy/done=%b, expected 00", {busy, done});
    end
  endtask

  task automatic test_zero_dim();
    start_run(3'd0, 3'd3, 32'd0);
    n_checks++;
    if ({busy, done, pass, timeout} !== 4'b0110 || cnt !== 16'd0) begin
      n_fail++; $display("FAIL zero_dim: got busy/done/pass/timeout=%b cnt=%0d, expected 0110 cnt=0",
                         {busy, done, pass, timeout}, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_exact_2x2();
    test_3x3_ignore();
    test_tolerance();
    test_backpressure();
    test_watchdog();
    test_async_reset();
    test_zero_dim();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
